control_unit: RTL and testbench

Instruction sequencer that drives the accumulator ALU and the register file over the shared 8-bit bus. It fetches one-byte instructions (plus a one-byte operand for jumps) from instruction RAM and decodes them. In a single EXEC cycle per instruction it emits `alu_op`, accumulator strobes, bus-source select and register write enables. It is the initiator for the ALU's control inputs; the ALU stays a pure responder.

---
 rtl/control_unit_pkg.sv | 38 +++
 rtl/cu_decode.sv | 68 ++++++
 rtl/control_unit.sv | 94 +++++++++
 tb/tb_control_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared opcode, state and ALU codes for the instruction sequencer and its decoder.
package control_unit_pkg;

    typedef enum logic [2:0] {
        CU_IDLE   = 3'd0,
        CU_FETCH  = 3'd1,
        CU_DECODE = 3'd2,
        CU_EXEC   = 3'd3,
        CU_JUMP   = 3'd4,
        CU_HALT   = 3'd5
    } cu_state_e;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_LDAC  = 4'h1;
    localparam logic [3:0] OP_STAC  = 4'h2;
    localparam logic [3:0] OP_ADD   = 4'h3;
    localparam logic [3:0] OP_MUL   = 4'h4;
    localparam logic [3:0] OP_DIV   = 4'h5;
    localparam logic [3:0] OP_MOD   = 4'h6;
    localparam logic [3:0] OP_INCAC = 4'h7;
    localparam logic [3:0] OP_CLAC  = 4'h8;
    localparam logic [3:0] OP_JMP   = 4'h9;
    localparam logic [3:0] OP_JZ    = 4'hA;
    localparam logic [3:0] OP_HALT  = 4'hF;

    localparam logic [2:0] ALU_NONE = 3'd0;
    localparam logic [2:0] ALU_ADD  = 3'd1;
    localparam logic [2:0] ALU_MUL  = 3'd2;
    localparam logic [2:0] ALU_DIV  = 3'd3;
    localparam logic [2:0] ALU_MOD  = 3'd4;

    localparam logic [3:0] BUS_AC = 4'd8;

    function automatic logic is_jump(input logic [3:0] op);
        return (op == OP_JMP) || (op == OP_JZ);
    endfunction

endpackage

// File: rtl/cu_decode.sv
// Combinational decode of the instruction register into ALU, accumulator, bus and
// register-file strobes; everything stays at its idle value outside EXEC.
module cu_decode
    import control_unit_pkg::*;
(
    input  logic       exec_i,
    input  logic [7:0] ir_i,
    output logic [2:0] alu_op_o,
    output logic       ac_wen_o,
    output logic       ac_inc_o,
    output logic       ac_rst_o,
    output logic [3:0] bus_sel_o,
    output logic [7:0] reg_wen_o,
    output logic       err_o
);

    logic [3:0] opcode;
    logic [2:0] rsel;
    logic       unused_ir_bit3;

    assign opcode         = ir_i[7:4];
    assign rsel           = ir_i[2:0];
    assign unused_ir_bit3 = ir_i[3];

    always_comb begin
        alu_op_o  = ALU_NONE;
        ac_wen_o  = 1'b0;
        ac_inc_o  = 1'b0;
        ac_rst_o  = 1'b0;
        bus_sel_o = 4'd0;
        reg_wen_o = 8'd0;
        err_o     = 1'b0;
        if (exec_i) begin
            unique case (opcode)
                OP_NOP, OP_JMP, OP_JZ, OP_HALT: ;
                OP_LDAC: begin
                    bus_sel_o = {1'b0, rsel};
                    ac_wen_o  = 1'b1;
                end
                OP_STAC: begin
                    bus_sel_o = BUS_AC;
                    reg_wen_o = 8'd1 << rsel;
                end
                OP_ADD: begin
                    bus_sel_o = {1'b0, rsel};
                    alu_op_o  = ALU_ADD;
                end
                OP_MUL: begin
                    bus_sel_o = {1'b0, rsel};
                    alu_op_o  = ALU_MUL;
                end
                OP_DIV: begin
                    bus_sel_o = {1'b0, rsel};
                    alu_op_o  = ALU_DIV;
                end
                OP_MOD: begin
                    bus_sel_o = {1'b0, rsel};
                    alu_op_o  = ALU_MOD;
                end
                OP_INCAC: ac_inc_o = 1'b1;
                OP_CLAC:  ac_rst_o = 1'b1;
                // 0xB-0xE: flag and otherwise behave as NOP
                default:  err_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: fetches bytes from instruction RAM, steps through
// FETCH/DECODE/EXEC (plus JUMP for branches) and drives the ALU/register strobes.
module control_unit
    import control_unit_pkg::*;
(
    input  logic       Clk,
    input  logic       RST,
    input  logic       start,
    output logic [7:0] iram_addr,
    input  logic [7:0] iram_data,
    input  logic       ac_zero,
    output logic [2:0] alu_op,
    output logic       ac_wen,
    output logic       ac_inc,
    output logic       ac_rst,
    output logic [3:0] bus_sel,
    output logic [7:0] reg_wen,
    output logic       busy,
    output logic       halted,
    output logic       err
);

    cu_state_e  state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;

    always_ff @(posedge Clk) begin
        if (RST) begin
            state_q <= CU_IDLE;
            pc_q    <= 8'h00;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unique case (state_q)
            CU_IDLE: begin
                if (start) begin
                    state_d = CU_FETCH;
                end
            end
            CU_FETCH: state_d = CU_DECODE;
            CU_DECODE: begin
                ir_d    = iram_data;
                pc_d    = pc_q + 8'd1;
                state_d = CU_EXEC;
            end
            CU_EXEC: begin
                if (is_jump(ir_q[7:4])) begin
                    state_d = CU_JUMP;
                end else if (ir_q[7:4] == OP_HALT) begin
                    state_d = CU_HALT;
                end else begin
                    state_d = CU_FETCH;
                end
            end
            CU_JUMP: begin
                // iram_data now holds the operand byte addressed during EXEC
                if ((ir_q[7:4] == OP_JMP) || ac_zero) begin
                    pc_d = iram_data;
                end else begin
                    pc_d = pc_q + 8'd1;
                end
                state_d = CU_FETCH;
            end
            CU_HALT: state_d = CU_HALT;
            default: state_d = CU_IDLE;
        endcase
    end

    assign iram_addr = pc_q;
    assign busy      = (state_q != CU_IDLE) && (state_q != CU_HALT);
    assign halted    = (state_q == CU_HALT);

    cu_decode u_decode (
        .exec_i    (state_q == CU_EXEC),
        .ir_i      (ir_q),
        .alu_op_o  (alu_op),
        .ac_wen_o  (ac_wen),
        .ac_inc_o  (ac_inc),
        .ac_rst_o  (ac_rst),
        .bus_sel_o (bus_sel),
        .reg_wen_o (reg_wen),
        .err_o     (err)
    );

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench: an instruction-level interpreter expands each program into the
// expected per-cycle output trace, and a monitor compares it against the sequencer.
module tb_control_unit;
    import control_unit_pkg::*;

    typedef struct packed {
        logic       busy;
        logic       halted;
        logic       err;
        logic       ac_wen;
        logic       ac_inc;
        logic       ac_rst;
        logic [2:0] alu;
        logic [3:0] bus;
        logic [7:0] wen;
        logic [7:0] addr;
    } rec_t;

    logic       Clk = 1'b0;
    logic       RST;
    logic       start;
    logic       ac_zero;
    logic [7:0] iram_addr;
    logic [7:0] iram_data;
    logic [2:0] alu_op;
    logic       ac_wen, ac_inc, ac_rst;
    logic [3:0] bus_sel;
    logic [7:0] reg_wen;
    logic       busy, halted, err;

    logic [7:0] ram [256];
    rec_t       exp_q [$];
    int         total = 0;
    int         bad   = 0;
    logic       saw_mul = 1'b0;

    control_unit dut (
        .Clk       (Clk),
        .RST       (RST),
        .start     (start),
        .iram_addr (iram_addr),
        .iram_data (iram_data),
        .ac_zero   (ac_zero),
        .alu_op    (alu_op),
        .ac_wen    (ac_wen),
        .ac_inc    (ac_inc),
        .ac_rst    (ac_rst),
        .bus_sel   (bus_sel),
        .reg_wen   (reg_wen),
        .busy      (busy),
        .halted    (halted),
        .err       (err)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) iram_data <= ram[iram_addr];

    function automatic rec_t idle_rec(input logic b, input logic h, input logic [7:0] a);
        rec_t r;
        r        = '0;
        r.busy   = b;
        r.halted = h;
        r.alu    = ALU_NONE;
        r.addr   = a;
        return r;
    endfunction

    function automatic rec_t cur_rec();
        rec_t r;
        r.busy   = busy;
        r.halted = halted;
        r.err    = err;
        r.ac_wen = ac_wen;
        r.ac_inc = ac_inc;
        r.ac_rst = ac_rst;
        r.alu    = alu_op;
        r.bus    = bus_sel;
        r.wen    = reg_wen;
        r.addr   = iram_addr;
        return r;
    endfunction

    task automatic check(input string name, input rec_t got, input rec_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (busy,halted,err,wen,inc,rst,alu,bus,regwen,addr)",
                     name, got, want);
        end
    endtask

    always @(negedge Clk) begin
        if ((busy || halted) && exp_q.size() > 0) begin
            rec_t e;
            e = exp_q.pop_front();
            check("trace", cur_rec(), e);
        end
        if (alu_op == ALU_MUL) saw_mul = 1'b1;
    end

    // Instruction-level interpreter: walks the program and emits one record per cycle.
    task automatic build_trace(input int max_instr, input logic az,
                               output logic hlt, output logic [7:0] end_pc);
        logic [7:0] pc, nx, ins;
        int         op, r;
        rec_t       e;
        pc  = 8'h00;
        hlt = 1'b0;
        for (int n = 0; n < max_instr; n++) begin
            ins = ram[pc];
            op  = int'(ins[7:4]);
            r   = int'(ins[2:0]);
            nx  = pc + 8'd1;
            exp_q.push_back(idle_rec(1'b1, 1'b0, pc));
            exp_q.push_back(idle_rec(1'b1, 1'b0, pc));
            e = idle_rec(1'b1, 1'b0, nx);
            case (op)
                1: begin e.bus = 4'(r); e.ac_wen = 1'b1; end
                2: begin e.bus = 4'd8; e.wen = 8'(1 << r); end
                3: begin e.bus = 4'(r); e.alu = ALU_ADD; end
                4: begin e.bus = 4'(r); e.alu = ALU_MUL; end
                5: begin e.bus = 4'(r); e.alu = ALU_DIV; end
                6: begin e.bus = 4'(r); e.alu = ALU_MOD; end
                7: e.ac_inc = 1'b1;
                8: e.ac_rst = 1'b1;
                11, 12, 13, 14: e.err = 1'b1;
                default: ;
            endcase
            exp_q.push_back(e);
            if (op == 9 || op == 10) begin
                exp_q.push_back(idle_rec(1'b1, 1'b0, nx));
                pc = (op == 9 || az) ? ram[nx] : pc + 8'd2;
            end else if (op == 15) begin
                exp_q.push_back(idle_rec(1'b0, 1'b1, nx));
                hlt = 1'b1;
                pc  = nx;
                break;
            end else begin
                pc = nx;
            end
        end
        end_pc = pc;
    endtask

    task automatic do_reset();
        @(negedge Clk);
        RST   = 1'b1;
        start = 1'b0;
        @(negedge Clk);
        check("reset", cur_rec(), idle_rec(1'b0, 1'b0, 8'h00));
        RST = 1'b0;
    endtask

    task automatic run_prog(input int max_instr, input logic az);
        logic       hlt;
        logic [7:0] end_pc;
        int         cyc;
        build_trace(max_instr, az, hlt, end_pc);
        ac_zero = az;
        @(negedge Clk);
        start = 1'b1;
        cyc   = 0;
        while (exp_q.size() > 0 && cyc < max_instr * 4 + 10) begin
            @(negedge Clk);
            // start is toggled freely while running; it must be ignored outside IDLE
            start = 1'($urandom_range(0, 1));
            cyc++;
        end
        start = 1'b0;
        total++;
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL trace_timeout: %0d records left after %0d cycles", exp_q.size(), cyc);
            exp_q.delete();
        end
        if (hlt) begin
            repeat (3) @(negedge Clk);
            check("halt_hold", cur_rec(), idle_rec(1'b0, 1'b1, end_pc));
        end
        do_reset();
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    endtask

    initial begin
        RST     = 1'b1;
        start   = 1'b0;
        ac_zero = 1'b0;
        clear_ram();
        repeat (2) @(negedge Clk);
        check("reset_initial", cur_rec(), idle_rec(1'b0, 1'b0, 8'h00));
        RST = 1'b0;

        clear_ram();
        ram[0] = 8'h11; ram[1] = 8'h33; ram[2] = 8'hF0;
        run_prog(10, 1'b0);

        clear_ram();
        ram[0] = 8'h70; ram[1] = 8'h80; ram[2] = 8'h25; ram[3] = 8'hF0;
        run_prog(10, 1'b0);

        clear_ram();
        ram[0] = 8'hA0; ram[1] = 8'h10; ram[2] = 8'hF0; ram[8'h10] = 8'hF0;
        run_prog(10, 1'b1);
        run_prog(10, 1'b0);

        clear_ram();
        ram[0] = 8'h90; ram[1] = 8'hFF; ram[8'hFF] = 8'h00;
        run_prog(3, 1'b0);

        clear_ram();
        ram[0] = 8'hC0; ram[1] = 8'h18; ram[2] = 8'hF0;
        run_prog(10, 1'b0);

        // Reset while the MUL instruction sits in DECODE must suppress its strobe.
        clear_ram();
        ram[0] = 8'h41; ram[1] = 8'hF0;
        saw_mul = 1'b0;
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        @(negedge Clk);
        RST = 1'b1;
        @(negedge Clk);
        check("reset_in_decode", cur_rec(), idle_rec(1'b0, 1'b0, 8'h00));
        RST = 1'b0;
        repeat (4) @(negedge Clk);
        check("idle_after_abort", cur_rec(), idle_rec(1'b0, 1'b0, 8'h00));
        total++;
        if (saw_mul) begin
            bad++;
            $display("FAIL no_mul_after_abort: alu_op showed ALU_MUL, required never");
        end

        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
            run_prog(24, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
